// File: rtl/serial_byte_loader.sv
// Serial-to-parallel loader: assembles WIDTH-bit frames and writes them to an auto-incrementing register address.
// Optional feature: define PARITY_CHECK_EN to require an even-parity bit after every frame.
module serial_byte_loader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  input  logic              in_clear,
  output logic              wrt,
  output logic [WIDTH-1:0]  d,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              frame_err
);

  // state    | meaning
  // S_IDLE   | no bits held, waiting for the first bit of a frame
  // S_SHIFT  | collecting data bits
  // S_COMMIT | one-cycle write strobe to the bank
  // S_PARITY | waiting for the even-parity bit (PARITY_CHECK_EN only)
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
`ifdef PARITY_CHECK_EN
  localparam logic [1:0] S_PARITY = 2'd3;
`endif

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             accept;

  assign in_ready = (state != S_COMMIT);
  assign wrt      = (state == S_COMMIT);
  assign busy     = (count != '0) || (state != S_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST != 0) sr_next = {sr[WIDTH-2:0], in_bit};
    else                sr_next = {in_bit, sr[WIDTH-1:1]};
  end

`ifndef PARITY_CHECK_EN
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      sr      <= '0;
      d       <= '0;
      wr_addr <= '0;
`ifdef PARITY_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
`ifdef PARITY_CHECK_EN
      frame_err <= 1'b0;
`endif
      case (state)
        S_IDLE, S_SHIFT: begin
          if (in_clear) begin
            state <= S_IDLE;
            count <= '0;
            sr    <= '0;
          end else if (accept) begin
            sr    <= sr_next;
            count <= count + 1'b1;
            if (count == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
              state <= S_PARITY;
`else
              state <= S_COMMIT;
              d     <= sr_next;
`endif
            end else begin
              state <= S_SHIFT;
            end
          end
        end
`ifdef PARITY_CHECK_EN
        S_PARITY: begin
          if (in_clear) begin
            state <= S_IDLE;
            count <= '0;
            sr    <= '0;
          end else if (accept) begin
            count <= '0;
            sr    <= '0;
            // even parity: data ones plus parity bit must total an even number
            if (^{sr, in_bit}) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else begin
              d     <= sr;
              state <= S_COMMIT;
            end
          end
        end
`endif
        S_COMMIT: begin
          state   <= S_IDLE;
          count   <= '0;
          sr      <= '0;
          wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
          sr    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Scoreboard bench for serial_byte_loader: directed frames push expected writes, a monitor checks each strobe.
module tb_serial_byte_loader;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_bit, in_clear;
  logic       in_ready, wrt, busy, frame_err;
  logic [7:0] d;
  logic [1:0] wr_addr;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int writes_expected = 0;
  logic [9:0] exp_q [$];   // {addr, data}
  logic [1:0] exp_addr;
  bit         in_reset;

  serial_byte_loader #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .in_clear(in_clear), .wrt(wrt), .d(d), .wr_addr(wr_addr), .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // monitor: runs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!in_reset) begin
      check("in_ready_vs_wrt", {31'd0, in_ready}, {31'd0, ~wrt});
`ifndef PARITY_CHECK_EN
      check("frame_err_tied", {31'd0, frame_err}, 32'd0);
`endif
      if (wrt === 1'b1) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wrt: actual addr %0h data %0h required no write", wr_addr, d);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("wr_data", {24'd0, d}, {24'd0, e[7:0]});
          check("wr_addr", {30'd0, wr_addr}, {30'd0, e[9:8]});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    int n;
    in_valid = 1'b1;
    in_bit   = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL ready_timeout: actual in_ready %b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_data(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // full frame (plus correct parity when enabled); expectation pushed first
  task automatic send_frame(input logic [7:0] v);
    exp_q.push_back({exp_addr, v});
    writes_expected++;
    send_data(v);
`ifdef PARITY_CHECK_EN
    send_bit(^v);
`endif
    exp_addr = exp_addr + 2'd1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] fr [5];
    fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'hC3; fr[3] = 8'h7E; fr[4] = 8'h80;
    in_reset = 1'b1;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_clear = 1'b0;
    exp_addr = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    in_reset = 1'b0;

    // 1: reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wrt", {31'd0, wrt}, 32'd0);
    check("rst_d", {24'd0, d}, 32'd0);
    check("rst_addr", {30'd0, wr_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // 2: 0xA5 MSB first, strobe on the cycle after the last bit
    send_frame(8'hA5);
    check("lat_wrt", {31'd0, wrt}, 32'd1);
    check("lat_d", {24'd0, d}, 32'hA5);
    check("lat_addr", {30'd0, wr_addr}, 32'd0);
    idle_cycle();
    check("post_wrt", {31'd0, wrt}, 32'd0);
    check("post_addr", {30'd0, wr_addr}, 32'd1);
    check("post_d_hold", {24'd0, d}, 32'hA5);

    // 3: five back-to-back frames, addresses 1,2,3,0,1
    for (int i = 0; i < 5; i++) send_frame(fr[i]);
    idle_cycle();
    check("b2b_addr", {30'd0, wr_addr}, {30'd0, exp_addr});
    check("b2b_busy", {31'd0, busy}, 32'd0);

    // 4: clear after 3 bits, bit in same cycle dropped
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("pre_clear_busy", {31'd0, busy}, 32'd1);
    in_clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    in_clear = 1'b0; in_valid = 1'b0;
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_wrt", {31'd0, wrt}, 32'd0);
    check("clear_d_hold", {24'd0, d}, 32'h80);
    check("clear_addr_hold", {30'd0, wr_addr}, {30'd0, exp_addr});
    send_frame(8'hFF);
    idle_cycle();

    // 5: reset mid-frame
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr = 2'd0;
    check("midrst_wrt", {31'd0, wrt}, 32'd0);
    check("midrst_addr", {30'd0, wr_addr}, 32'd0);
    check("midrst_d", {24'd0, d}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A);
    idle_cycle();
    check("after_rst_addr", {30'd0, wr_addr}, 32'd1);

`ifdef PARITY_CHECK_EN
    // 6: bad parity then good parity for 0x03
    send_data(8'h03);
    send_bit(1'b1);
    in_valid = 1'b0;
    check("par_err", {31'd0, frame_err}, 32'd1);
    check("par_err_wrt", {31'd0, wrt}, 32'd0);
    idle_cycle();
    check("par_err_pulse", {31'd0, frame_err}, 32'd0);
    check("par_err_addr", {30'd0, wr_addr}, {30'd0, exp_addr});
    send_frame(8'h03);
    check("par_ok_wrt", {31'd0, wrt}, 32'd1);
    check("par_ok_d", {24'd0, d}, 32'h03);
    idle_cycle();
`endif

    repeat (3) @(posedge clk);
    #1;
    check("writes_total", writes_seen, writes_expected);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual timeout required finish");
    $fatal(1);
  end
endmodule
